// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - N-way arbiter feeding a single registered output slot.
// Define MUX_RR_ARBITER_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module mux_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_src
);

    localparam int SW = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic [SW-1:0] win_idx;
    logic          win_found;
    logic [SW:0]   cand;
    logic          load_en;
    logic          load;

    // Scan from ptr upward with wrap; the extra bit in cand absorbs the carry before the modulo.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (SW+1)'(k);
            if (cand >= (SW+1)'(N)) begin
                cand = cand - (SW+1)'(N);
            end
            if (!win_found && req_valid[cand[SW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        req_ready  = '0;
        load_en    = (state == EMPTY) | out_ready;
        // Reset gates the handshake so no requester sees an accept it cannot complete.
        load       = rst_n & load_en & win_found;

        if (load) begin
            req_ready[win_idx] = 1'b1;
            state_next         = FULL;
`ifdef MUX_RR_ARBITER_ROUND_ROBIN_EN
            if (win_idx == SW'(N-1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = win_idx + SW'(1);
            end
`else
            ptr_next = '0;
`endif
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // The output register only changes on a load; draining just clears the valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= '0;
        end else if (load) begin
            out_data <= req_data[win_idx*W +: W];
            out_src  <= win_idx;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and scoreboarded checks for mux_rr_arbiter.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  out_src;

    int checks = 0;
    int errors = 0;

`ifdef MUX_RR_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mux_rr_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h13121110;
        out_ready = 1'b1;
        tick();
        #1 chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_src", 32'(out_src), 32'h0);
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    logic [3:0] g_exp [5];
    logic [7:0] d_exp [5];
    logic [3:0] g34   [4];
    logic [1:0] s34   [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        if (RR) begin
            g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            d_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
            g34   = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
            s34   = '{2'd1, 2'd3, 2'd1, 2'd3};
        end else begin
            g_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
            d_exp = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
            g34   = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
            s34   = '{2'd1, 2'd1, 2'd1, 2'd1};
        end

        // Idle after reset
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b0000;
            out_ready = c[0];
            #1;
            chk("idle_valid", 32'(out_valid), 32'h0);
            chk("idle_ready", 32'(req_ready), 32'h0);
            tick();
        end

        // All requesters busy, downstream always ready
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b1111;
            req_data  = 32'h13121110;
            out_ready = 1'b1;
            #1;
            chk("all_grant", 32'(req_ready), 32'(g_exp[c]));
            if (c > 0) begin
                chk("all_valid", 32'(out_valid), 32'h1);
                chk("all_data", 32'(out_data), 32'(d_exp[c-1]));
            end
            tick();
        end
        req_valid = 4'b0000;
        #1;
        chk("all_last_data", 32'(out_data), 32'(d_exp[4]));
        chk("all_last_ready", 32'(req_ready), 32'h0);
        tick();
        #1 chk("all_drained", 32'(out_valid), 32'h0);

        // Single requester with back-pressure
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h00A50000;
        out_ready = 1'b0;
        #1 chk("bp_accept", 32'(req_ready), 32'h4);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_src", 32'(out_src), 32'h2);
            tick();
        end
        req_valid = 4'b0000;
        out_ready = 1'b1;
        #1 chk("bp_still_valid", 32'(out_valid), 32'h1);
        tick();
        #1 chk("bp_empty", 32'(out_valid), 32'h0);

        // Requesters 1 and 3 competing
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b1010;
            req_data  = 32'h13121110;
            out_ready = 1'b1;
            #1;
            chk("pair_grant", 32'(req_ready), 32'(g34[c]));
            if (c > 0) chk("pair_src", 32'(out_src), 32'(s34[c-1]));
            tick();
        end

        // Reset while holding a word
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000005A;
        out_ready = 1'b0;
        tick();
        req_valid = 4'b1111;
        #1;
        chk("mid_full", 32'(out_valid), 32'h1);
        chk("mid_data", 32'(out_data), 32'h5A);
        rst_n = 1'b0;
        #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n     = 1'b1;
        req_data  = 32'h13121110;
        out_ready = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_data0", 32'(out_data), 32'h0);
        chk("mid_ptr0", 32'(req_ready), 32'h1);
        tick();
        #1 chk("mid_src", 32'(out_src), 32'h0);

        // Random traffic against a register-level model
        do_reset();
        begin
            bit         m_full = 1'b0;
            logic [7:0] m_data = '0;
            int         m_src  = 0;
            int         m_ptr  = 0;
            for (int c = 0; c < 10000; c++) begin
                int  w;
                bit  le;
                req_valid = 4'($urandom);
                req_data  = $urandom;
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                chk("rnd_valid", 32'(out_valid), 32'(m_full));
                if (m_full) begin
                    chk("rnd_data", 32'(out_data), 32'(m_data));
                    chk("rnd_src", 32'(out_src), 32'(m_src));
                end
                le = !m_full || out_ready;
                w  = pick(req_valid, m_ptr);
                chk("rnd_grant", 32'(req_ready), (le && w >= 0) ? (32'h1 << w) : 32'h0);
                if (le && w >= 0) begin
                    m_full = 1'b1;
                    m_data = req_data[w*8 +: 8];
                    m_src  = w;
                    if (RR) m_ptr = (w + 1) % 4;
                end else if (le) begin
                    m_full = 1'b0;
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, data width per requester.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  N  bit i set: requester i offers data.
REQ-006 SHALL have port req_data  input  N*W  requester i data at bits [i*W +: W].
REQ-007 SHALL have port req_ready  output  N  bit i set: requester i word accepted this cycle.
REQ-008 SHALL have port out_valid  output  1  output register holds a word.
REQ-009 SHALL have port out_data  output  W  selected word, registered.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_src  output  $clog2(N)  index of requester that supplied out_data, registered.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load_en = (state==EMPTY) | out_ready; a new word is taken only when load_en=1.
REQ-014 SHALL choose a winner combinationally as the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N.
REQ-015 SHALL drive req_ready one-hot on the winner when load_en=1 and any req_valid is set; all zero otherwise.
REQ-016 SHALL never assert req_ready[i] while req_valid[i]=0.
REQ-017 SHALL, on a load, register out_data=winner data, out_src=winner index, out_valid=1, and set ptr=(winner+1) mod N.
REQ-018 SHALL have one-cycle latency: a word accepted in cycle t appears on out_data in cycle t+1.
REQ-019 SHALL hold out_data, out_src, out_valid and ptr stable while FULL and out_ready=0.
REQ-020 SHALL, when FULL with out_ready=1 and no req_valid set, go to EMPTY (out_valid=0) next cycle.
REQ-021 SHALL, when FULL with out_ready=1 and a req_valid set, accept the new word in the same cycle (back-to-back, 100% throughput).
REQ-022 SHALL ignore out_ready while EMPTY.
REQ-023 SHALL leave ptr unchanged in cycles with no load.
REQ-024 SHALL guarantee that a requester holding req_valid=1 is granted within N loads (round-robin mode).

Reset
REQ-025 SHALL, on rising clk with rst_n=0, set state=EMPTY, out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-026 SHALL hold req_ready all zero during any cycle with rst_n=0.
REQ-027 SHALL discard any word held in the output register when reset is asserted mid-transfer; no word is re-issued.

Configuration
REQ-028 SHALL use macro MUX_RR_ARBITER_ROUND_ROBIN_EN to select the priority policy.
REQ-029 SHALL, with MUX_RR_ARBITER_ROUND_ROBIN_EN defined, use the rotating ptr behaviour of REQ-014/REQ-017.
REQ-030 SHALL, without MUX_RR_ARBITER_ROUND_ROBIN_EN, use fixed priority (lowest index wins, ptr held at 0); REQ-024 then does not apply.

Verification
REQ-031 SHALL cover: reset, then req_valid=4'b0000 for 5 cycles -> out_valid=0, req_ready=0 throughout.
REQ-032 SHALL cover: RR mode, req_valid=4'b1111, data i=8'h10+i, out_ready=1 -> req_ready sequence 0001,0010,0100,1000,0001; out_data 10,11,12,13,10 one cycle later.
REQ-033 SHALL cover: req_valid=4'b0100, data 8'hA5, out_ready=0 for 3 cycles -> out_data=A5, out_src=2 held, req_ready=0 after first accept; out_ready=1 -> out_valid=0 next cycle.
REQ-034 SHALL cover: fixed-priority build, req_valid=4'b1010, out_ready=1 -> req_ready=0010 every cycle; requester 3 never granted.
REQ-035 SHALL cover: rst_n=0 for one cycle while FULL with out_data=8'h5A -> next cycle out_valid=0, out_data=0, ptr=0.
REQ-036 SHALL cover: random req_valid/out_ready for 10000 cycles -> scoreboard: every accepted word delivered once, in order, one-hot req_ready, no word lost while out_ready=0.
